// File: rtl/reg_serial_readout_if.sv
// reg_serial_readout handshake bundle.
// Load side, serial side and status.
interface reg_serial_readout_if #(
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] D;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             busy;
  logic             done;
  logic [CW-1:0]    bits_left;

  modport master (
    output D,
    output load_valid,
    output sout_ready,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  busy,
    input  done,
    input  bits_left
  );

  modport slave (
    input  D,
    input  load_valid,
    input  sout_ready,
    output load_ready,
    output sout,
    output sout_valid,
    output busy,
    output done,
    output bits_left
  );
endinterface

// File: rtl/reg_serial_readout.sv
// Parallel-in/serial-out register readout.
// Captures a word, streams it under valid/ready.
module reg_serial_readout #(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic            clk,
  input logic            rst,
  reg_serial_readout_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic             out_bit;

  assign out_bit = LSB_FIRST ? shreg[0]
                             : shreg[WIDTH-1];

  // Outputs decode only from registered state.
  assign bus.load_ready = (state == IDLE);
  assign bus.sout_valid = (state == SHIFT);
  assign bus.busy       = (state == SHIFT);
  assign bus.sout       = (state == SHIFT) & out_bit;
  assign bus.done       = done_q;
  assign bus.bits_left  = cnt;

  // Load/shift FSM; done pulses after last bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.load_valid) begin
            shreg <= bus.D;
            cnt   <= CW'(WIDTH);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.sout_ready) begin
            if (LSB_FIRST)
              shreg <= {1'b0, shreg[WIDTH-1:1]};
            else
              shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/reg_serial_readout.md
# reg_serial_readout

Parallel-in/serial-out readout port for a 32-bit architectural register value. It is the read-side counterpart of the load-enabled 32-bit register: it captures a full word on a load handshake, then streams it out one bit per accepted transfer under a valid/ready handshake. It sits between the processor's register/datapath side and a narrow serial consumer, such as a debug scan link or test output pin.

## Interface
- WIDTH, 32: word width in bits; must be ≥ 2.
- LSB_FIRST, 1: 1 shifts out bit 0 first; 0 shifts out bit WIDTH-1 first.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset. Asserting low clears all state immediately; release is synchronous to clk by the integrator.
- D  in  WIDTH  parallel word to capture.
- load_valid  in  1  producer offers D.
- load_ready  out  1  block can accept a word; high only in IDLE.
- sout  out  1  current serial bit.
- sout_valid  out  1  sout holds a valid bit; high only in SHIFT.
- sout_ready  in  1  consumer accepts sout this cycle.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse after the final bit is accepted.
- bits_left  out  $clog2(WIDTH+1)  bits still to transfer; 0 in IDLE.

## Operation
- States: IDLE and SHIFT. Reset state is IDLE.
- Reset values: load_ready=1, sout_valid=0, sout=0, busy=0, done=0, bits_left=0. The shift register is cleared to 0.
- IDLE:
  - load_ready=1.
  - On load_valid=1 at a rising edge: capture D into the shift register, set bits_left=WIDTH, and go to SHIFT.
  - load_valid=0 leaves the state unchanged.
- SHIFT:
  - sout_valid=1 and load_ready=0.
  - sout is shreg[0] when LSB_FIRST=1, otherwise shreg[WIDTH-1]. sout is 0 whenever sout_valid=0.
  - A transfer occurs on a rising edge with sout_valid and sout_ready both high. Each transfer shifts the register one position toward the output end, filling with 0, and decrements bits_left.
  - With sout_ready=0, sout, bits_left and the shift register hold.
- Final transfer (bits_left=1 and a transfer occurs): go to IDLE, set bits_left=0, and assert done for exactly the next cycle.
- load_valid is ignored in SHIFT. D changing during SHIFT has no effect.
- Reset asserted mid-SHIFT aborts the word with no done pulse. All outputs return to reset values asynchronously.
- A new word may be loaded in the cycle where done=1, because the block is already in IDLE.

## Timing
- Load-to-first-bit latency: 1 cycle. The load edge is at T0, and sout_valid=1 with bit 0 (or bit WIDTH-1) is presented in cycle T0+1.
- With sout_ready held high, a word takes WIDTH consecutive cycles (T0+1 through T0+WIDTH).
  - done=1 and load_ready=1 in cycle T0+WIDTH+1.
  - Minimum load-to-load spacing is WIDTH+1 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from sout_ready or load_valid to any output.
- sout_valid, once asserted, stays high until the final transfer; it never drops while bits remain.

## Test plan
- Reset values:
  - Stimulus: assert rst=0 asynchronously between edges.
  - Required: load_ready=1, sout_valid=0, busy=0, done=0, bits_left=0 immediately, without waiting for a clock edge.
- Basic LSB-first word:
  - Stimulus: load D=0xA5A50F0F with sout_ready=1.
  - Required: sout sequence over 32 cycles is 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1. done pulses once, at cycle 33 after the load edge.
- MSB-first:
  - Stimulus: set LSB_FIRST=0 and load D=0x80000001.
  - Required: first bit 1, then 30 zeros, then last bit 1. bits_left counts 32 down to 0.
- Backpressure:
  - Stimulus: load 0x0000000F, then toggle sout_ready 1,0,0,1,…
  - Required: sout and bits_left hold while sout_ready=0. Exactly 32 bits are transferred, the first four are 1, and done fires only after the 32nd accepted bit.
- Load ignored while busy:
  - Stimulus: pulse load_valid with D=0xFFFFFFFF mid-word while streaming 0x00000000.
  - Required: all 32 output bits are 0, and load_ready stays 0 until done.
- Reset mid-word and back-to-back loads:
  - Stimulus: assert rst at bits_left=17.
  - Required: no done pulse, and the block is in IDLE.
  - Follow-up stimulus: load 0x12345678, then load 0x9ABCDEF0 in the done cycle.
  - Required: both words stream intact with exactly one idle cycle between them.
